sat_accum_seq: RTL

//  Frame-based streaming accumulator that sequences one signed saturating adder.
//  A start pulse arms a frame of len samples; samples arrive over a valid/ready

---
 rtl/sat_accum_pkg.sv | 21 ++
 rtl/signed_sat_add.sv | 35 +++
 rtl/sat_accum_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sat_accum_pkg.sv
// Shared types and constants for the saturating frame accumulator.
package sat_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Clamp a requested frame length to the largest supported frame.
    function automatic logic [31:0] clamp_len(input logic [31:0] req, input logic [31:0] n_max);
        logic [31:0] res;
        if (req > n_max) begin
            res = n_max;
        end else begin
            res = req;
        end
        return res;
    endfunction

endpackage

// File: rtl/signed_sat_add.sv
// Combinational two's-complement adder that clamps to the W-bit signed range.
module signed_sat_add #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         clip
);

    localparam logic [W-1:0] MAX_C = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_C = {1'b1, {(W-1){1'b0}}};

    logic [W:0] wide_s;

    assign wide_s = {a[W-1], a} + {b[W-1], b};

    // Overflow shows as disagreement between the extra sign bit and the W-bit sign.
    always_comb begin
        sum  = wide_s[W-1:0];
        clip = 1'b0;
        if (wide_s[W] != wide_s[W-1]) begin
            clip = 1'b1;
            if (wide_s[W]) begin
                sum = MIN_C;
            end else begin
                sum = MAX_C;
            end
        end else begin
            sum  = wide_s[W-1:0];
            clip = 1'b0;
        end
    end

endmodule

// File: rtl/sat_accum_seq.sv
// Frame accumulator: start arms a frame of len samples, each accepted sample is
// saturating-added into a running sum, and the clipped sum is offered on out_*.
module sat_accum_seq
    import sat_accum_pkg::*;
#(
    parameter int W     = 4,
    parameter int N_MAX = 15,
    parameter int CNT_W = $clog2(N_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_sat,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             sat_q, sat_d;

    logic [W-1:0]     add_sum_s;
    logic             add_clip_s;
    logic [CNT_W-1:0] len_eff_s;

    signed_sat_add #(.W(W)) u_add (
        .a    (acc_q),
        .b    (in_data),
        .sum  (add_sum_s),
        .clip (add_clip_s)
    );

    assign len_eff_s = CNT_W'(clamp_len(32'(len), 32'(N_MAX)));

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sat_q   <= sat_d;
        end
    end

    // Next-state and datapath update; start is only honoured in IDLE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    cnt_d = '0;
                    sat_d = 1'b0;
                    len_d = len_eff_s;
                    if (len_eff_s == CNT_W'(0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = add_sum_s;
                    sat_d = sat_q | add_clip_s;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == len_q - CNT_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so they never follow in_valid/out_ready.
    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        if (state_q == DONE) begin
            out_data = acc_q;
            out_sat  = sat_q;
        end else begin
            out_data = '0;
            out_sat  = 1'b0;
        end
    end

endmodule
